wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters: ALU (req 0) and LSU (req 1).

---
 rtl/wb_arbiter_pkg.sv | 22 ++
 rtl/wb_arbiter_rr_arb2.sv | 22 ++
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and types for the writeback arbiter
//
// Purpose : default widths, FSM state encoding and requester index constants
//           used by wb_arbiter and rr_arb2.
// Ports   : none (package)
// Config  : WB_ARB_CLEAR_EN selects whether reset enters WB_ST_CLEAR.

package wb_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef enum logic {
    WB_ST_CLEAR = 1'b0,
    WB_ST_RUN   = 1'b1
  } wb_state_e;

  // Bit positions in the request/grant vectors; also the encoding of last_grant.
  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_LSU = 1;

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// rtl/wb_arbiter_rr_arb2.sv - two-way round-robin grant, purely combinational
//
// Purpose : grants the single valid requester, or on a tie the one that was
//           not granted last. The last-grant state lives in the caller.
// Ports   : req  in  [1:0]  request vector (bit 0 = requester 0)
//           last in  1      index of the requester granted most recently
//           gnt  out [1:0]  one-hot grant, zero when no request

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter for ALU and LSU writeback
//
// Purpose : shares one register-file write port between ALU (req 0) and
//           LSU (req 1) with valid/ready handshakes and round-robin priority.
//           Writes to x0 are accepted but never reach the register file.
//           With WB_ARB_CLEAR_EN defined, reset first clears x1..x31.
// Ports   : clk, srst                       clock, sync active-high reset
//           alu_valid/alu_waddr/alu_wdata   ALU write request
//           alu_ready                       ALU accepted this cycle (comb)
//           lsu_valid/lsu_waddr/lsu_wdata   LSU write request
//           lsu_ready                       LSU accepted this cycle (comb)
//           reg_wen/reg_waddr/reg_wdata     register-file write (registered)
//           busy                            clear sequence running (registered)
// Config  : macro WB_ARB_CLEAR_EN enables the post-reset clear sequence.

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_waddr,
  input  logic [XLEN-1:0] alu_wdata,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_waddr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_ready,
  output logic            reg_wen,
  output logic [AW-1:0]   reg_waddr,
  output logic [XLEN-1:0] reg_wdata,
  output logic            busy
);

  wb_state_e       state_q, state_d;
  logic            last_q, last_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            run_ok;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

`ifdef WB_ARB_CLEAR_EN
  localparam logic [AW-1:0] LAST_ADDR = '1;
  logic [AW-1:0] cnt_q, cnt_d;
`endif

  assign req = {lsu_valid, alu_valid};

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  // Readies are gated by srst so nothing is accepted in a cycle that is
  // about to be wiped by reset.
  assign run_ok    = (state_q == WB_ST_RUN) && !srst;
  assign alu_ready = run_ok && gnt[WB_REQ_ALU];
  assign lsu_ready = run_ok && gnt[WB_REQ_LSU];
  assign xfer      = (alu_ready && alu_valid) || (lsu_ready && lsu_valid);

  assign sel_addr  = gnt[WB_REQ_LSU] ? lsu_waddr : alu_waddr;
  assign sel_data  = gnt[WB_REQ_LSU] ? lsu_wdata : alu_wdata;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef WB_ARB_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      WB_ST_CLEAR: begin
`ifdef WB_ARB_CLEAR_EN
        wen_d   = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = WB_ST_RUN;
        end
`else
        state_d = WB_ST_RUN;
`endif
      end
      WB_ST_RUN: begin
        if (xfer) begin
          last_d = gnt[WB_REQ_LSU];
          // x0 is hardwired zero: accept the request but suppress the write,
          // leaving the held address/data untouched.
          if (sel_addr != '0) begin
            wen_d   = 1'b1;
            waddr_d = sel_addr;
            wdata_d = sel_data;
          end
        end
      end
      default: state_d = WB_ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
`ifdef WB_ARB_CLEAR_EN
      state_q <= WB_ST_CLEAR;
      cnt_q   <= AW'(1);
`else
      state_q <= WB_ST_RUN;
`endif
      // last_grant = LSU so the first tie goes to the ALU.
      last_q  <= 1'b1;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
`ifdef WB_ARB_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign reg_wen   = wen_q;
  assign reg_waddr = waddr_q;
  assign reg_wdata = wdata_q;

`ifdef WB_ARB_CLEAR_EN
  assign busy = (state_q == WB_ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking scoreboard bench for wb_arbiter

module tb_wb_arbiter;

`ifdef WB_ARB_CLEAR_EN
  localparam int CLEAR_CYCLES = 31;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_waddr = '0;
  logic [31:0] alu_wdata = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_waddr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_ready;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        busy;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk       (clk),
    .srst      (srst),
    .alu_valid (alu_valid),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_waddr (lsu_waddr),
    .lsu_wdata (lsu_wdata),
    .lsu_ready (lsu_ready),
    .reg_wen   (reg_wen),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .busy      (busy)
  );

  typedef struct packed {
    logic        wen;
    logic        chk;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   model_last = 1;
  int   clear_left = 0;

  // Drives one cycle, runs the reference model and pushes the expected
  // register-file write. At the negedge it hands back the expectation that
  // the now-visible registered outputs must match.
  task automatic drive(input logic rst,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       output logic ea, output logic el, output logic eb,
                       output logic hv, output exp_t p);
    exp_t e;
    logic ga, gl;
    logic [4:0] wa;
    @(posedge clk);
    #1;
    srst = rst; alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    e = '0; ea = 1'b0; el = 1'b0; eb = 1'b0;
    if (rst) begin
      clear_left = CLEAR_CYCLES;
      model_last = 1;
    end else if (clear_left > 0) begin
      eb = 1'b1;
      e.wen = 1'b1; e.chk = 1'b1;
      e.addr = 5'(32 - clear_left);
      e.data = '0;
      clear_left--;
    end else begin
      ga = (av && lv) ? (model_last == 1) : av;
      gl = lv && !ga;
      ea = ga; el = gl;
      if (ga || gl) begin
        model_last = gl ? 1 : 0;
        wa = gl ? la : aa;
        if (wa != 5'd0) begin
          e.wen = 1'b1; e.chk = 1'b1;
          e.addr = wa;
          e.data = gl ? ld : ad;
        end
      end
    end
    q.push_back(e);
    @(negedge clk);
    hv = 1'b0;
    p = '0;
    if (q.size() >= 2) begin
      p = q.pop_front();
      hv = 1'b1;
    end
  endtask

  task automatic reset_dut(input int n);
    logic ea, el, eb, hv;
    exp_t p;
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
    for (int i = 0; i < CLEAR_CYCLES; i++) drive(0, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
  endtask

  task automatic test_reset;
    logic ea, el, eb, hv;
    exp_t p;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88, ea, el, eb, hv, p);
      total++;
      if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
        bad++; $display("FAIL reset_ready got %b%b want 00", alu_ready, lsu_ready);
      end
    end
    total++;
    if (reg_wen !== 1'b0 || reg_waddr !== 5'd0 || reg_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_regs got %b/%0d/%h want 0/0/0", reg_wen, reg_waddr, reg_wdata);
    end
    total++;
    if (busy !== (CLEAR_CYCLES > 0)) begin
      bad++; $display("FAIL reset_busy got %b want %b", busy, CLEAR_CYCLES > 0);
    end
    for (int i = 0; i < CLEAR_CYCLES + 2; i++) begin
      drive(0, i <= CLEAR_CYCLES, 5'd7, 32'h77, 0, 0, 0, ea, el, eb, hv, p);
      total++;
      if (alu_ready !== ea || lsu_ready !== el) begin
        bad++; $display("FAIL reset_first_req got %b%b want %b%b", alu_ready, lsu_ready, ea, el);
      end
      if (hv) begin
        total++;
        if (reg_wen !== p.wen || (p.chk && (reg_waddr !== p.addr || reg_wdata !== p.data))) begin
          bad++; $display("FAIL reset_first_out got %b/%0d/%h want %b/%0d/%h", reg_wen, reg_waddr, reg_wdata, p.wen, p.addr, p.data);
        end
      end
    end
  endtask

  task automatic test_single_alu;
    logic ea, el, eb, hv;
    exp_t p;
    drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, ea, el, eb, hv, p);
    total++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      bad++; $display("FAIL single_ready got %b%b want 10", alu_ready, lsu_ready);
    end
    drive(0, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
    total++;
    if (reg_wen !== 1'b1 || reg_waddr !== 5'd5 || reg_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_out got %b/%0d/%h want 1/5/deadbeef", reg_wen, reg_waddr, reg_wdata);
    end
  endtask

  task automatic test_contention;
    logic ea, el, eb, hv;
    exp_t p;
    logic [31:0] ad, ld;
    int writes;
    reset_dut(1);
    ad = 32'd1; ld = 32'd2; writes = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, i < 4, 5'd3, ad, i < 4, 5'd4, ld, ea, el, eb, hv, p);
      if (i < 4) begin
        total++;
        if (alu_ready !== (i % 2 == 0) || lsu_ready !== (i % 2 == 1)) begin
          bad++; $display("FAIL contention_grant%0d got %b%b want alternating", i, alu_ready, lsu_ready);
        end
      end
      if (alu_ready && alu_valid) ad = ad + 32'h10;
      if (lsu_ready && lsu_valid) ld = ld + 32'h10;
      if (hv) begin
        if (reg_wen === 1'b1) writes++;
        total++;
        if (reg_wen !== p.wen || (p.chk && (reg_waddr !== p.addr || reg_wdata !== p.data))) begin
          bad++; $display("FAIL contention_out got %b/%0d/%h want %b/%0d/%h", reg_wen, reg_waddr, reg_wdata, p.wen, p.addr, p.data);
        end
      end
    end
    total++;
    if (writes != 4) begin
      bad++; $display("FAIL contention_count got %0d want 4", writes);
    end
  endtask

  task automatic test_x0_drop;
    logic ea, el, eb, hv;
    exp_t p;
    drive(0, 0, 0, 0, 1, 5'd0, 32'h1234, ea, el, eb, hv, p);
    total++;
    if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
      bad++; $display("FAIL x0_ready got %b%b want 01", alu_ready, lsu_ready);
    end
    drive(0, 1, 5'd9, 32'hAA, 1, 5'd10, 32'hBB, ea, el, eb, hv, p);
    total++;
    if (reg_wen !== 1'b0) begin
      bad++; $display("FAIL x0_wen got %b want 0", reg_wen);
    end
    total++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      bad++; $display("FAIL x0_tie got %b%b want 10", alu_ready, lsu_ready);
    end
  endtask

  task automatic test_idle_hold;
    logic ea, el, eb, hv;
    exp_t p;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
      if (i == 0) begin
        total++;
        if (reg_wen !== 1'b1 || reg_waddr !== 5'd9 || reg_wdata !== 32'hAA) begin
          bad++; $display("FAIL idle_prev got %b/%0d/%h want 1/9/aa", reg_wen, reg_waddr, reg_wdata);
        end
      end else begin
        total++;
        if (reg_wen !== 1'b0 || reg_waddr !== 5'd9 || reg_wdata !== 32'hAA) begin
          bad++; $display("FAIL idle_hold got %b/%0d/%h want 0/9/aa", reg_wen, reg_waddr, reg_wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic ea, el, eb, hv;
    exp_t p;
    drive(0, 0, 0, 0, 1, 5'd12, 32'hC0FFEE, ea, el, eb, hv, p);
    drive(1, 1, 5'd6, 32'h66, 0, 0, 0, ea, el, eb, hv, p);
    total++;
    if (alu_ready !== 1'b0 || reg_wen !== 1'b1 || reg_waddr !== 5'd12) begin
      bad++; $display("FAIL mid_inflight got rdy=%b wen=%b a=%0d want 0/1/12", alu_ready, reg_wen, reg_waddr);
    end
    drive(0, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
    total++;
    if (reg_wen !== 1'b0 || reg_waddr !== 5'd0 || reg_wdata !== 32'd0) begin
      bad++; $display("FAIL mid_reset got %b/%0d/%h want 0/0/0", reg_wen, reg_waddr, reg_wdata);
    end
    for (int i = 0; i < CLEAR_CYCLES; i++) drive(0, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
    drive(0, 1, 5'd3, 32'h3, 1, 5'd4, 32'h4, ea, el, eb, hv, p);
    total++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      bad++; $display("FAIL mid_tie_after got %b%b want 10", alu_ready, lsu_ready);
    end
  endtask

`ifdef WB_ARB_CLEAR_EN
  task automatic run_clear_checked(input string name, input int cycles, output int writes, output int acc_cycle);
    logic ea, el, eb, hv;
    exp_t p;
    logic pend;
    writes = 0; acc_cycle = -1; pend = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      drive(0, pend, 5'd9, 32'h99, 0, 0, 0, ea, el, eb, hv, p);
      total++;
      if (busy !== eb || alu_ready !== ea || lsu_ready !== el) begin
        bad++; $display("FAIL %s_cyc%0d got busy=%b rdy=%b%b want %b/%b%b", name, i, busy, alu_ready, lsu_ready, eb, ea, el);
      end
      if (alu_ready && pend) begin
        acc_cycle = i; pend = 1'b0;
      end
      if (hv) begin
        if (reg_wen === 1'b1 && reg_wdata === 32'd0) writes++;
        total++;
        if (reg_wen !== p.wen || (p.chk && (reg_waddr !== p.addr || reg_wdata !== p.data))) begin
          bad++; $display("FAIL %s_out%0d got %b/%0d/%h want %b/%0d/%h", name, i, reg_wen, reg_waddr, reg_wdata, p.wen, p.addr, p.data);
        end
      end
    end
  endtask

  task automatic test_clear;
    logic ea, el, eb, hv;
    exp_t p;
    int writes, acc;
    drive(1, 1, 5'd9, 32'h99, 0, 0, 0, ea, el, eb, hv, p);
    run_clear_checked("clear", 34, writes, acc);
    total++;
    if (writes != 31) begin
      bad++; $display("FAIL clear_count got %0d want 31", writes);
    end
    total++;
    if (acc != 32) begin
      bad++; $display("FAIL clear_accept got %0d want 32", acc);
    end
  endtask

  task automatic test_reset_mid_clear;
    logic ea, el, eb, hv;
    exp_t p;
    int writes, acc;
    drive(1, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
    for (int i = 1; i < 10; i++) drive(0, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
    drive(1, 0, 0, 0, 0, 0, 0, ea, el, eb, hv, p);
    total++;
    if (reg_wen !== 1'b1 || reg_waddr !== 5'd9) begin
      bad++; $display("FAIL midclr_before got %b/%0d want 1/9", reg_wen, reg_waddr);
    end
    run_clear_checked("midclr", 34, writes, acc);
    total++;
    if (writes != 31) begin
      bad++; $display("FAIL midclr_count got %0d want 31", writes);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_x0_drop();
    test_idle_hold();
    test_reset_mid();
`ifdef WB_ARB_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
